// File: rtl/window_mac_if.sv
// Purpose: window request/capture stream and result stream of window_mac bundled as one port.
// Latency: none (wires only).
// Backpressure: none; next_window paces upstream, result stream is a one-cycle strobe with no ready.
//
// Ports/signals:
//   window_flat  : K packed signed elements, element n at [n*DATA_WIDTH +: DATA_WIDTH]
//   window_valid : one-cycle pulse qualifying window_flat
//   next_window  : request for the next window (high only while waiting for one)
//   result       : signed result, held until the next strobe
//   result_valid : one-cycle strobe qualifying result/result_row/result_col
//   result_row/result_col : output-map coordinates of result
// modport master = upstream/consumer side, modport slave = the MAC engine.

interface window_mac_if #(
   parameter int DATA_WIDTH = 8,
   parameter int K          = 9,
   parameter int ACC_WIDTH  = 20,
   parameter int ROW_W      = 3,
   parameter int COL_W      = 3
);
   logic [DATA_WIDTH*K-1:0]      window_flat;
   logic                         window_valid;
   logic                         next_window;
   logic signed [ACC_WIDTH-1:0]  result;
   logic                         result_valid;
   logic [ROW_W-1:0]             result_row;
   logic [COL_W-1:0]             result_col;

   modport master (
      output window_flat, window_valid,
      input  next_window, result, result_valid, result_row, result_col
   );

   modport slave (
      input  window_flat, window_valid,
      output next_window, result, result_valid, result_row, result_col
   );
endinterface

// File: rtl/window_mac.sv
// Purpose: sequential KxK window dot product (one MAC per cycle) + bias + optional ReLU over an OUT_H x OUT_W map.
// Latency: result_valid K+1 cycles after the edge that samples window_valid; K+2 cycles per result plus upstream delay.
// Backpressure: requests windows with registered next_window; window_valid outside the request state is ignored.
//
// Ports:
//   clk, rst     : single clock, synchronous active-high reset
//   start        : starts a run; kernel_flat and bias are latched in that cycle
//   kernel_flat  : K packed signed kernel elements (same packing as windows)
//   bias         : signed bias added to each result
//   busy         : high whenever the engine is not idle
//   all_done     : one-cycle pulse in the cycle after the final result strobe
//   win_if       : window request/capture and result stream (slave side)

module window_mac #(
   parameter int DATA_WIDTH = 8,
   parameter int K_H        = 3,
   parameter int K_W        = 3,
   parameter int OUT_H      = 6,
   parameter int OUT_W      = 6,
   parameter int ACC_WIDTH  = 20,
   parameter int RELU       = 1
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                start,
   input  logic [DATA_WIDTH*K_H*K_W-1:0]       kernel_flat,
   input  logic signed [ACC_WIDTH-1:0]         bias,
   output logic                                busy,
   output logic                                all_done,
   window_mac_if.slave                         win_if
);

   localparam int K     = K_H * K_W;
   localparam int KW    = DATA_WIDTH * K;
   localparam int PW    = 2 * DATA_WIDTH;
   localparam int IDX_W = (K > 1)     ? $clog2(K)     : 1;
   localparam int ROW_W = (OUT_H > 1) ? $clog2(OUT_H) : 1;
   localparam int COL_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;

   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(K - 1);
   localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(OUT_H - 1);
   localparam logic [COL_W-1:0] COL_LAST = COL_W'(OUT_W - 1);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_REQ  = 3'd1,
      S_MAC  = 3'd2,
      S_OUT  = 3'd3,
      S_DONE = 3'd4
   } state_t;

   state_t                      state_q, state_d;
   logic [KW-1:0]               ker_q, ker_d;
   logic signed [ACC_WIDTH-1:0] bias_q, bias_d;
   logic [KW-1:0]               win_q, win_d;
   logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
   logic [IDX_W-1:0]            idx_q, idx_d;
   logic [ROW_W-1:0]            row_q, row_d;
   logic [COL_W-1:0]            col_q, col_d;

   logic                        next_window_q, next_window_d;
   logic signed [ACC_WIDTH-1:0] result_q, result_d;
   logic                        result_valid_q, result_valid_d;
   logic [ROW_W-1:0]            result_row_q, result_row_d;
   logic [COL_W-1:0]            result_col_q, result_col_d;
   logic                        busy_q, busy_d;
   logic                        all_done_q, all_done_d;

   // Element pair selected by idx, sign-extended to product width. The low PW
   // bits of an unsigned multiply of sign-extended operands equal the signed product.
   logic [DATA_WIDTH-1:0]       win_elem, ker_elem;
   logic [PW-1:0]               win_ext, ker_ext, prod;
   logic signed [ACC_WIDTH-1:0] prod_ext;

   always_comb begin
      win_elem = win_q[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
      ker_elem = ker_q[int'(idx_q) * DATA_WIDTH +: DATA_WIDTH];
      win_ext  = {{DATA_WIDTH{win_elem[DATA_WIDTH-1]}}, win_elem};
      ker_ext  = {{DATA_WIDTH{ker_elem[DATA_WIDTH-1]}}, ker_elem};
      prod     = win_ext * ker_ext;
      prod_ext = {{(ACC_WIDTH-PW){prod[PW-1]}}, prod};
   end

   always_comb begin
      state_d      = state_q;
      ker_d        = ker_q;
      bias_d       = bias_q;
      win_d        = win_q;
      acc_d        = acc_q;
      idx_d        = idx_q;
      row_d        = row_q;
      col_d        = col_q;
      result_d     = result_q;
      result_row_d = result_row_q;
      result_col_d = result_col_q;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               ker_d   = kernel_flat;
               bias_d  = bias;
               row_d   = '0;
               col_d   = '0;
               idx_d   = '0;
               state_d = S_REQ;
            end
         end
         S_REQ: begin
            if (win_if.window_valid) begin
               win_d   = win_if.window_flat;
               acc_d   = bias_q;
               idx_d   = '0;
               state_d = S_MAC;
            end
         end
         S_MAC: begin
            // Wraps modulo 2^ACC_WIDTH by construction.
            acc_d = acc_q + prod_ext;
            if (idx_q == IDX_LAST) begin
               idx_d   = '0;
               state_d = S_OUT;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         S_OUT: begin
            result_d     = ((RELU != 0) && acc_q[ACC_WIDTH-1]) ? '0 : acc_q;
            result_row_d = row_q;
            result_col_d = col_q;
            if (col_q != COL_LAST) begin
               col_d = col_q + COL_W'(1);
            end else begin
               col_d = '0;
               row_d = row_q + ROW_W'(1);
            end
            state_d = ((row_q == ROW_LAST) && (col_q == COL_LAST)) ? S_DONE : S_REQ;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // next_window/busy track the state being entered so next_window is high
      // exactly while in REQ. result_valid/all_done are decoded from the state
      // being left, so the strobe lands K+1 cycles after capture and all_done
      // follows the final strobe.
      next_window_d  = (state_d == S_REQ);
      busy_d         = (state_d != S_IDLE);
      result_valid_d = (state_q == S_OUT);
      all_done_d     = (state_q == S_DONE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= S_IDLE;
         ker_q          <= '0;
         bias_q         <= '0;
         win_q          <= '0;
         acc_q          <= '0;
         idx_q          <= '0;
         row_q          <= '0;
         col_q          <= '0;
         next_window_q  <= 1'b0;
         result_q       <= '0;
         result_valid_q <= 1'b0;
         result_row_q   <= '0;
         result_col_q   <= '0;
         busy_q         <= 1'b0;
         all_done_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         ker_q          <= ker_d;
         bias_q         <= bias_d;
         win_q          <= win_d;
         acc_q          <= acc_d;
         idx_q          <= idx_d;
         row_q          <= row_d;
         col_q          <= col_d;
         next_window_q  <= next_window_d;
         result_q       <= result_d;
         result_valid_q <= result_valid_d;
         result_row_q   <= result_row_d;
         result_col_q   <= result_col_d;
         busy_q         <= busy_d;
         all_done_q     <= all_done_d;
      end
   end

   assign win_if.next_window  = next_window_q;
   assign win_if.result       = result_q;
   assign win_if.result_valid = result_valid_q;
   assign win_if.result_row   = result_row_q;
   assign win_if.result_col   = result_col_q;
   assign busy                = busy_q;
   assign all_done            = all_done_q;

endmodule

// File: tb/tb_window_mac.sv
// Purpose: self-checking bench for window_mac (RELU=1 and RELU=0 instances fed identically).
// Latency: checks result_valid K+1 cycles after the window_valid sampling edge.
// Backpressure: bench answers next_window with a random gap; injects stray window_valid/start pulses.

module tb_window_mac;

   localparam int DW    = 8;
   localparam int K     = 9;
   localparam int KW    = DW * K;
   localparam int ACC   = 20;
   localparam int OUT_H = 6;
   localparam int OUT_W = 6;

   logic                  clk;
   logic                  rst;
   logic                  start;
   logic [KW-1:0]         kernel_flat;
   logic signed [ACC-1:0] bias;
   logic                  busy1, done1, busy0, done0;

   int checks = 0;
   int errors = 0;

   window_mac_if #(.DATA_WIDTH(DW), .K(K), .ACC_WIDTH(ACC), .ROW_W(3), .COL_W(3)) if1 ();
   window_mac_if #(.DATA_WIDTH(DW), .K(K), .ACC_WIDTH(ACC), .ROW_W(3), .COL_W(3)) if0 ();

   assign if0.window_flat  = if1.window_flat;
   assign if0.window_valid = if1.window_valid;

   window_mac #(.RELU(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start), .kernel_flat(kernel_flat), .bias(bias),
      .busy(busy1), .all_done(done1), .win_if(if1.slave)
   );

   window_mac #(.RELU(0)) u_dut0 (
      .clk(clk), .rst(rst), .start(start), .kernel_flat(kernel_flat), .bias(bias),
      .busy(busy0), .all_done(done0), .win_if(if0.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [KW-1:0]         ker;
      logic [KW-1:0]         win;
      logic signed [ACC-1:0] b;
      int                    gap;
      logic signed [ACC-1:0] exp1;
      logic signed [ACC-1:0] exp0;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string name, input logic signed [63:0] act, input logic signed [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Dot product + bias in wide integer arithmetic, then reduced to ACC bits.
   function automatic logic signed [ACC-1:0] model(input logic [KW-1:0] k, input logic [KW-1:0] w,
                                                   input logic signed [ACC-1:0] b, input bit relu);
      longint s;
      logic signed [ACC-1:0] r;
      s = longint'(b);
      for (int n = 0; n < K; n++)
         s += longint'($signed(w[n*DW +: DW])) * longint'($signed(k[n*DW +: DW]));
      r = s[ACC-1:0];
      if (relu && r < 0) r = '0;
      return r;
   endfunction

   function automatic logic [KW-1:0] rand_vec();
      logic [KW-1:0] v;
      for (int j = 0; j < K; j++) v[j*DW +: DW] = DW'($urandom);
      return v;
   endfunction

   function automatic logic signed [ACC-1:0] rand_bias();
      logic [31:0] u;
      u = $urandom;
      return u[ACC-1:0];
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   // Kernel/bias are scrambled right after the start cycle; the run must use the latched copy.
   task automatic start_run(input logic [KW-1:0] k, input logic signed [ACC-1:0] b);
      kernel_flat = k;
      bias        = b;
      start       = 1'b1;
      @(posedge clk); #1;
      start       = 1'b0;
      kernel_flat = ~k;
      bias        = ~b;
   endtask

   // Waits for next_window, answers after 'gap' cycles, then waits for the result strobe.
   // Returns with time at #1 after the strobe edge; lat = cycles from capture edge, -1 on timeout.
   task automatic serve(input logic [KW-1:0] w, input int gap, input bit noise, output int lat);
      int waited;
      bit nw_bad;
      lat    = -1;
      waited = 0;
      nw_bad = 1'b0;
      while (if1.next_window !== 1'b1 && waited < 40) begin
         @(posedge clk); #1;
         waited++;
      end
      if (if1.next_window !== 1'b1) begin
         chk("next_window_timeout", 0, 1);
         return;
      end
      repeat (gap) begin @(posedge clk); #1; end
      if1.window_flat  = w;
      if1.window_valid = 1'b1;
      @(posedge clk); #1;
      if1.window_valid = 1'b0;
      for (int n = 1; n <= 30; n++) begin
         @(posedge clk); #1;
         if (noise && n == 3) begin
            if1.window_valid = 1'b1;
            start            = 1'b1;
            if1.window_flat  = rand_vec();
            kernel_flat      = rand_vec();
            bias             = rand_bias();
         end
         if (noise && n == 4) begin
            if1.window_valid = 1'b0;
            start            = 1'b0;
         end
         if (noise && n == 9) if1.window_valid = 1'b1;
         if (if1.result_valid === 1'b1) begin
            lat = n;
            break;
         end
         if (if1.next_window !== 1'b0) nw_bad = 1'b1;
      end
      if1.window_valid = 1'b0;
      start            = 1'b0;
      chk("next_window_low_while_computing", nw_bad, 0);
   endtask

   task automatic full_run(input bit noise_on);
      logic [KW-1:0]         k, w;
      logic signed [ACC-1:0] b;
      int lat;
      k = rand_vec();
      b = rand_bias();
      // Stray window_valid while idle must not start anything.
      if1.window_valid = 1'b1;
      @(posedge clk); #1;
      if1.window_valid = 1'b0;
      chk("idle_valid_busy", busy1, 0);
      chk("idle_valid_next_window", if1.next_window, 0);
      start_run(k, b);
      for (int i = 0; i < OUT_H * OUT_W; i++) begin
         w = rand_vec();
         serve(w, $urandom_range(0, 3), noise_on && ($urandom_range(0, 2) == 0), lat);
         chk("run_latency", lat, K + 1);
         chk("run_result_relu", if1.result, model(k, w, b, 1'b1));
         chk("run_result_norelu", if0.result, model(k, w, b, 1'b0));
         chk("run_row", if1.result_row, i / OUT_W);
         chk("run_col", if1.result_col, i % OUT_W);
         chk("run_busy", busy1, 1);
         chk("run_all_done_early", done1, 0);
      end
      @(posedge clk); #1;
      chk("all_done_pulse", done1, 1);
      chk("all_done_no_strobe", if1.result_valid, 0);
      @(posedge clk); #1;
      chk("all_done_single", done1, 0);
      chk("busy_after_run", busy1, 0);
      chk("next_window_after_run", if1.next_window, 0);
   endtask

   initial begin
      int lat;
      logic [KW-1:0] ones;

      vecs[0] = '{ker: {K{8'h01}}, win: {K{8'h01}}, b: 20'sd0, gap: 3, exp1: 20'sd9, exp0: 20'sd9};
      vecs[1] = '{ker: {K{8'h02}}, win: {K{8'hFF}}, b: 20'sd5, gap: 0, exp1: 20'sd0, exp0: -20'sd13};
      vecs[2] = '{ker: {K{8'h01}}, win: {K{8'h01}}, b: 20'sh7FFFF, gap: 1, exp1: 20'sd0, exp0: 20'sh80008};
      vecs[3] = '{ker: {K{8'h80}}, win: {K{8'h80}}, b: 20'sd0, gap: 2, exp1: 20'sd147456, exp0: 20'sd147456};
      vecs[4] = '{ker: 72'h00_00_00_00_03_00_00_00_00, win: 72'h09_08_07_06_05_04_03_02_01,
                  b: -20'sd20, gap: 0, exp1: 20'sd0, exp0: -20'sd5};
      ones = {K{8'h01}};

      rst              = 1'b1;
      start            = 1'b0;
      kernel_flat      = '0;
      bias             = '0;
      if1.window_flat  = '0;
      if1.window_valid = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      chk("reset_busy", busy1, 0);
      chk("reset_next_window", if1.next_window, 0);
      chk("reset_result_valid", if1.result_valid, 0);
      chk("reset_all_done", done1, 0);
      chk("reset_result", if1.result, 0);
      rst = 1'b0;

      // Directed single-window vectors, each a fresh run.
      for (int v = 0; v < 5; v++) begin
         do_reset();
         start_run(vecs[v].ker, vecs[v].b);
         chk("vec_busy_after_start", busy1, 1);
         serve(vecs[v].win, vecs[v].gap, 1'b0, lat);
         chk("vec_latency", lat, K + 1);
         chk("vec_result_relu", if1.result, vecs[v].exp1);
         chk("vec_result_norelu", if0.result, vecs[v].exp0);
         chk("vec_row", if1.result_row, 0);
         chk("vec_col", if1.result_col, 0);
         @(posedge clk); #1;
         chk("vec_strobe_one_cycle", if1.result_valid, 0);
         chk("vec_result_held", if0.result, vecs[v].exp0);
      end

      // Reset in the 4th MAC cycle of the second window.
      do_reset();
      start_run(ones, 20'sd0);
      serve(ones, 0, 1'b0, lat);
      chk("pre_reset_result", if1.result, 9);
      if1.window_flat  = ones;
      if1.window_valid = 1'b1;
      @(posedge clk); #1;
      if1.window_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("mac_reset_busy", busy1, 0);
      chk("mac_reset_next_window", if1.next_window, 0);
      chk("mac_reset_result_valid", if1.result_valid, 0);
      chk("mac_reset_all_done", done1, 0);
      chk("mac_reset_result", if1.result, 0);
      chk("mac_reset_row", if1.result_row, 0);
      chk("mac_reset_col", if1.result_col, 0);
      start_run(vecs[4].ker, vecs[4].b);
      serve(vecs[4].win, 1, 1'b0, lat);
      chk("post_reset_latency", lat, K + 1);
      chk("post_reset_result", if0.result, -5);
      chk("post_reset_row", if1.result_row, 0);
      chk("post_reset_col", if1.result_col, 0);

      // Randomized full runs against the model, second one with stray pulses.
      do_reset();
      full_run(1'b0);
      full_run(1'b1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
